pipe_stage_elastic: RTL

- Parametrised, elastic successor to the fixed ID/EX control register, usable at any pipeline boundary (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries an arbitrary-width control/data payload, a destination register and its write enable.
- Uses a valid/ready handshake with a 2-entry skid buffer, so back-pressure does not need a combinational ready path.
- Supports synchronous flush with a defined bubble payload, and exposes destination info for the hazard unit.

---
 rtl/pipe_stage_elastic.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline register with a 2-entry skid buffer, synchronous flush and bubble-forced outputs.
// Optional performance counters are compiled in when PIPE_STAGE_PERF_EN is defined.
`timescale 1ns/1ps
module pipe_stage_elastic #(
  parameter int                DATA_W     = 64,
  parameter int                RD_W       = 5,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = {DATA_W{1'b0}}
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [RD_W-1:0]   in_rd,
  input  logic              in_rf_le,
  input  logic              in_nop,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [RD_W-1:0]   out_rd,
  output logic              out_rf_le,
  output logic              out_nop,
  output logic [1:0]        occ,
  output logic [RD_W-1:0]   skid_rd,
  output logic              skid_rf_le
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       bubble_cnt
`endif
);

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE   = 2'd1;
  localparam logic [1:0] S_TWO   = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] head_data_q, head_data_d, skid_data_q, skid_data_d;
  logic [RD_W-1:0]   head_rd_q, head_rd_d, skid_rd_q, skid_rd_d;
  logic              head_le_q, head_le_d, skid_le_q, skid_le_d;
  logic              head_nop_q, head_nop_d, skid_nop_q, skid_nop_d;
  logic              in_fire, out_fire, skid_valid;

  // Handshake: a transfer happens on a posedge where valid & ready are both high.
  // in_ready is a pure function of registered state, so no ready path runs through the stage.
  assign in_ready   = (state_q != S_TWO);
  assign out_valid  = (state_q != S_EMPTY);
  assign skid_valid = (state_q == S_TWO);
  assign in_fire    = in_valid & in_ready;
  assign out_fire   = out_valid & out_ready;
  assign occ        = state_q;

  always_comb begin
    state_d     = state_q;
    head_data_d = head_data_q;
    head_rd_d   = head_rd_q;
    head_le_d   = head_le_q;
    head_nop_d  = head_nop_q;
    skid_data_d = skid_data_q;
    skid_rd_d   = skid_rd_q;
    skid_le_d   = skid_le_q;
    skid_nop_d  = skid_nop_q;
    if (flush) begin
      state_d = S_EMPTY;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (in_fire) begin
            state_d     = S_ONE;
            head_data_d = in_data;
            head_rd_d   = in_rd;
            head_le_d   = in_rf_le;
            head_nop_d  = in_nop;
          end
        end
        S_ONE: begin
          if (in_fire && out_fire) begin
            head_data_d = in_data;
            head_rd_d   = in_rd;
            head_le_d   = in_rf_le;
            head_nop_d  = in_nop;
          end else if (in_fire) begin
            state_d     = S_TWO;
            skid_data_d = in_data;
            skid_rd_d   = in_rd;
            skid_le_d   = in_rf_le;
            skid_nop_d  = in_nop;
          end else if (out_fire) begin
            state_d = S_EMPTY;
          end
        end
        S_TWO: begin
          if (out_fire) begin
            state_d     = S_ONE;
            head_data_d = skid_data_q;
            head_rd_d   = skid_rd_q;
            head_le_d   = skid_le_q;
            head_nop_d  = skid_nop_q;
          end
        end
        default: state_d = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_EMPTY;
      head_data_q <= BUBBLE_VAL;
      head_rd_q   <= '0;
      head_le_q   <= 1'b0;
      head_nop_q  <= 1'b1;
      skid_data_q <= BUBBLE_VAL;
      skid_rd_q   <= '0;
      skid_le_q   <= 1'b0;
      skid_nop_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      head_data_q <= head_data_d;
      head_rd_q   <= head_rd_d;
      head_le_q   <= head_le_d;
      head_nop_q  <= head_nop_d;
      skid_data_q <= skid_data_d;
      skid_rd_q   <= skid_rd_d;
      skid_le_q   <= skid_le_d;
      skid_nop_q  <= skid_nop_d;
    end
  end

  // Empty slots read as bubbles so the hazard unit can use rd fields unqualified.
  assign out_data   = out_valid ? head_data_q : BUBBLE_VAL;
  assign out_rd     = out_valid ? head_rd_q   : '0;
  assign out_rf_le  = out_valid & head_le_q;
  assign out_nop    = out_valid ? head_nop_q  : 1'b1;
  assign skid_rd    = skid_valid ? skid_rd_q  : '0;
  assign skid_rf_le = skid_valid & skid_le_q;

`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] stall_cnt_q, bubble_cnt_q;

  // Counters saturate and are cleared by reset only; flush leaves them alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if (in_valid && !in_ready && (stall_cnt_q != 32'hFFFF_FFFF))
        stall_cnt_q <= stall_cnt_q + 32'd1;
      if (out_ready && !out_valid && (bubble_cnt_q != 32'hFFFF_FFFF))
        bubble_cnt_q <= bubble_cnt_q + 32'd1;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`else
  // Counters are absent in this build.
`endif

endmodule
